// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the next-PC selector encoding.
package pipe_pkg;

    localparam int unsigned     XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC   = 32'd4;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_HOLD   = 2'd3
    } next_pc_sel_t;

endpackage

// File: rtl/branch_target_adder.sv
// Combinational branch target: PC+4 of the branch plus its word-aligned offset.
// Wraps modulo 2^XLEN; no overflow indication is produced.
module branch_target_adder
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN = pipe_pkg::XLEN
) (
    input  logic               [XLEN-1:0] branch_pc_plus4,
    input  logic signed        [XLEN-1:0] branch_offset_sl2,
    output logic               [XLEN-1:0] br_target
);

    // Two's-complement add: a negative offset is just a large unsigned addend.
    always_comb begin
        br_target = branch_pc_plus4 + $unsigned(branch_offset_sl2);
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter and IF/ID PC+4 latch with branch/jump redirect, stall hold,
// one-cycle IF/ID flush and a saturating count of taken redirects.
module pc_redirect_unit
    import pipe_pkg::*;
#(
    parameter int unsigned     XLEN     = pipe_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = pipe_pkg::RESET_PC,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_pc_plus4,
    input  logic [XLEN-1:0]   branch_offset_sl2,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   if_id_pc_plus4,
    output logic              if_id_valid,
    output logic              flush,
    output logic [CNT_W-1:0]  redirect_count
);

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  br_target;
    logic [XLEN-1:0]  j_target;
    next_pc_sel_t     sel;

    logic [XLEN-1:0]  pc_nxt;
    logic [XLEN-1:0]  if_id_pc_plus4_nxt;
    logic             if_id_valid_nxt;
    logic             flush_nxt;
    logic             redirect;

    branch_target_adder #(
        .XLEN (XLEN)
    ) u_br_adder (
        .branch_pc_plus4   (branch_pc_plus4),
        .branch_offset_sl2 (branch_offset_sl2),
        .br_target         (br_target)
    );

    // Sequential fetch address and the pseudo-direct jump target.
    always_comb begin
        pc_plus4 = pc + XLEN'(PC_INC);
        j_target = {if_id_pc_plus4[XLEN-1:XLEN-4], jump_index, 2'b00};
    end

    // Priority select: a taken branch in EX is older than anything stalled or
    // jumping in ID, so it beats both; a jump under stall waits for the stall
    // to drop and is re-evaluated then.
    always_comb begin
        sel = SEL_SEQ;
        if (branch_taken) begin
            sel = SEL_BRANCH;
        end else if (stall) begin
            sel = SEL_HOLD;
        end else if (jump) begin
            sel = SEL_JUMP;
        end
    end

    // Next-state values for PC, IF/ID latch and flush from the selected path.
    always_comb begin
        pc_nxt             = pc_plus4;
        if_id_pc_plus4_nxt = pc_plus4;
        if_id_valid_nxt    = 1'b1;
        flush_nxt          = 1'b0;
        redirect           = 1'b0;
        unique case (sel)
            SEL_BRANCH: begin
                pc_nxt          = br_target;
                if_id_valid_nxt = 1'b0;
                flush_nxt       = 1'b1;
                redirect        = 1'b1;
            end
            SEL_JUMP: begin
                pc_nxt          = j_target;
                if_id_valid_nxt = 1'b0;
                flush_nxt       = 1'b1;
                redirect        = 1'b1;
            end
            SEL_HOLD: begin
                pc_nxt             = pc;
                if_id_pc_plus4_nxt = if_id_pc_plus4;
                if_id_valid_nxt    = if_id_valid;
            end
            default: begin
                pc_nxt             = pc_plus4;
                if_id_pc_plus4_nxt = pc_plus4;
                if_id_valid_nxt    = 1'b1;
            end
        endcase
    end

    // ---- IF -> ID stage boundary ----
    // PC and IF/ID register; reset wins over any redirect in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            if_id_pc_plus4 <= RESET_PC + XLEN'(PC_INC);
            if_id_valid    <= 1'b0;
            flush          <= 1'b0;
        end else begin
            pc             <= pc_nxt;
            if_id_pc_plus4 <= if_id_pc_plus4_nxt;
            if_id_valid    <= if_id_valid_nxt;
            flush          <= flush_nxt;
        end
    end

    // Saturating redirect counter, stepped once per taken branch or jump.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_count <= '0;
        end else if (redirect) begin
            redirect_count <= sat_inc(redirect_count);
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed and randomized stimulus for pc_redirect_unit against a
// cycle-level reference model of the PC/IF-ID behaviour.
module tb_pc_redirect_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall;
    logic              branch_taken;
    logic [XLEN-1:0]   branch_pc_plus4;
    logic [XLEN-1:0]   branch_offset_sl2;
    logic              jump;
    logic [25:0]       jump_index;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   if_id_pc_plus4;
    logic              if_id_valid;
    logic              flush;
    logic [CNT_W-1:0]  redirect_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_pc, m_ifpc;
    logic        m_valid, m_flush;
    int unsigned m_cnt;

    pc_redirect_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RST_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_pc_plus4   (branch_pc_plus4),
        .branch_offset_sl2 (branch_offset_sl2),
        .jump              (jump),
        .jump_index        (jump_index),
        .pc                (pc),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_valid       (if_id_valid),
        .flush             (flush),
        .redirect_count    (redirect_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge using the rules for PC selection.
    task automatic model_edge();
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (!rst_n) begin
            m_pc = RST_PC; m_ifpc = RST_PC + 32'd4; m_valid = 0; m_flush = 0; m_cnt = 0;
        end else if (branch_taken) begin
            m_pc = branch_pc_plus4 + branch_offset_sl2;
            m_ifpc = seq; m_valid = 0; m_flush = 1;
            if (m_cnt < 32'hFFFF) m_cnt = m_cnt + 1;
        end else if (jump && !stall) begin
            m_pc = {m_ifpc[31:28], jump_index, 2'b00};
            m_ifpc = seq; m_valid = 0; m_flush = 1;
            if (m_cnt < 32'hFFFF) m_cnt = m_cnt + 1;
        end else if (stall) begin
            m_flush = 0;
        end else begin
            m_pc = seq; m_ifpc = seq; m_valid = 1; m_flush = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    pc,                    m_pc);
        chk({tag, ".ifpc"},  if_id_pc_plus4,        m_ifpc);
        chk({tag, ".valid"}, {31'd0, if_id_valid},  {31'd0, m_valid});
        chk({tag, ".flush"}, {31'd0, flush},        {31'd0, m_flush});
        chk({tag, ".cnt"},   {16'd0, redirect_count}, m_cnt);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        rst_n = 1; stall = 0; branch_taken = 0; jump = 0;
    endtask

    task automatic do_branch(input logic [31:0] bpc, input logic [31:0] off);
        branch_taken = 1; branch_pc_plus4 = bpc; branch_offset_sl2 = off;
    endtask

    initial begin
        rst_n = 0; stall = 0; branch_taken = 0; jump = 0;
        branch_pc_plus4 = '0; branch_offset_sl2 = '0; jump_index = '0;
        m_pc = '0; m_ifpc = '0; m_valid = 0; m_flush = 0; m_cnt = 0;
        #2;

        // Reset state
        step("rst0");
        step("rst1");
        chk("rst.pc_const", pc, 32'h0);

        // Sequential fetch
        idle();
        for (int i = 0; i < 4; i++) step("seq");
        chk("seq.pc_c", pc, 32'h10);

        // Forward branch to 0x14, then flush must drop
        do_branch(32'h10, 32'h4);
        step("br_fwd");
        chk("br_fwd.pc_abs", pc, 32'h14);
        idle();
        step("br_fwd_after");
        chk("br_fwd.flush_drop", {31'd0, flush}, 32'd0);

        // Backward branch to 0x08
        do_branch(32'h10, 32'hFFFF_FFF8);
        step("br_back");
        chk("br_back.pc_abs", pc, 32'h08);
        idle();
        step("br_back_after");

        // Branch under stall wins
        stall = 1; do_branch(32'h100, 32'h40);
        step("br_stall");
        chk("br_stall.pc_abs", pc, 32'h140);
        branch_taken = 0;
        for (int i = 0; i < 3; i++) step("stall_hold");
        chk("stall.pc_abs", pc, 32'h140);

        // Set IF/ID PC+4 to 0x4000_0008, then jump
        idle();
        do_branch(32'h4000_0000, 32'h4);
        step("br_to_4000");
        idle();
        step("seq_4000");
        chk("pre_jump.ifpc", if_id_pc_plus4, 32'h4000_0008);
        jump = 1; jump_index = 26'h0000_100;
        step("jump");
        chk("jump.pc_abs", pc, 32'h4000_0400);
        idle();
        step("jump_after");

        // Jump under stall is not taken, taken once stall drops
        stall = 1; jump = 1; jump_index = 26'h3FF_FFFF;
        step("jump_stalled");
        stall = 0;
        step("jump_released");
        idle();
        step("jump_rel_after");

        // Jump and branch together: branch wins, count +1
        jump = 1; jump_index = 26'h155_5555; do_branch(32'h200, 32'h20);
        step("jump_br");
        chk("jump_br.pc_abs", pc, 32'h220);
        idle();
        step("jump_br_after");

        // PC wraps at top of address space
        do_branch(32'hFFFF_FFF8, 32'h4);
        step("to_top");
        chk("to_top.pc_abs", pc, 32'hFFFF_FFFC);
        idle();
        step("wrap");
        chk("wrap.pc_abs", pc, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst_n        = ($urandom_range(0, 49) != 0);
            stall        = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 4) == 0);
            jump         = ($urandom_range(0, 4) == 0);
            branch_pc_plus4   = $urandom & 32'hFFFF_FFFC;
            branch_offset_sl2 = $urandom & 32'hFFFF_FFFC;
            jump_index        = 26'($urandom);
            step("rand");
        end

        // Saturation: reset, then drive enough back-to-back branches to pass all-ones
        idle(); rst_n = 0;
        step("sat_rst");
        idle();
        for (int i = 0; i < 65535 + 3; i++) begin
            do_branch($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
            step("sat");
        end
        chk("sat.cnt_abs", {16'd0, redirect_count}, 32'h0000_FFFF);
        idle();
        step("sat_after");

        // Reset overrides a branch in the same cycle
        rst_n = 0; do_branch(32'h1000, 32'h40);
        step("rst_br");
        chk("rst_br.pc_abs", pc, RST_PC);
        chk("rst_br.cnt_abs", {16'd0, redirect_count}, 32'h0);
        idle();
        step("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
